// File: rtl/load_store_queue.sv
// In-order load/store queue: circular buffer with CDB operand wake-up, committed-store survival across flush
// and a single registered memory request; load data is sign/zero extended on the way back to the CDB.
module load_store_queue #(
  parameter int DEPTH    = 8,
  parameter int ROB_BITS = 4,
  parameter int CDB_N    = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      inst_valid,
  input  logic [3:0]                inst_type,
  input  logic [ROB_BITS-1:0]       inst_rob_idx,
  input  logic [31:0]               inst_r1,
  input  logic [31:0]               inst_r2,
  input  logic [ROB_BITS-1:0]       inst_dep1,
  input  logic [ROB_BITS-1:0]       inst_dep2,
  input  logic                      inst_has_dep1,
  input  logic                      inst_has_dep2,
  input  logic [11:0]               inst_offset,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      commit_valid,
  input  logic [ROB_BITS-1:0]       commit_rob_idx,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*ROB_BITS-1:0] cdb_idx,
  input  logic [CDB_N*32-1:0]       cdb_value,
  output logic                      wb_valid,
  output logic [ROB_BITS-1:0]       wb_idx,
  output logic [31:0]               wb_value,
  output logic                      st_done,
  output logic                      mem_valid,
  output logic                      mem_wr,
  output logic [2:0]                mem_len,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_ready,
  input  logic [31:0]               mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  logic [DEPTH-1:0]    r_vld, r_cmt, r_hd1, r_hd2;
  logic [3:0]          r_type [DEPTH];
  logic [ROB_BITS-1:0] r_tag  [DEPTH];
  logic [ROB_BITS-1:0] r_dep1 [DEPTH];
  logic [ROB_BITS-1:0] r_dep2 [DEPTH];
  logic [31:0]         r_r1   [DEPTH];
  logic [31:0]         r_r2   [DEPTH];
  logic [11:0]         r_off  [DEPTH];
  logic [PW-1:0]       r_head, r_tail;
  logic [PW:0]         r_count;
  state_t              r_state;
  logic                r_mem_valid, r_mem_wr;
  logic [2:0]          r_mem_len;
  logic [31:0]         r_mem_addr, r_mem_wdata;

  logic [32:0]         w_wk1 [DEPTH];
  logic [32:0]         w_wk2 [DEPTH];
  logic [32:0]         w_pk1, w_pk2;
  logic [DEPTH-1:0]    w_cmt_hit, w_cmt_eff, w_keep;
  logic [PW:0]         w_ncmt;
  logic [PW-1:0]       w_idx;
  logic                w_run, w_head_elig, w_done, w_pop, w_push;
  logic [31:0]         w_addr, w_ext;

  // {hit, value}; channels scanned high to low so the lowest matching channel wins
  function automatic logic [32:0] cdb_hit(input logic [ROB_BITS-1:0] tag, input logic [CDB_N-1:0] v,
                                          input logic [CDB_N*ROB_BITS-1:0] idx, input logic [CDB_N*32-1:0] val);
    logic [32:0] res;
    res = '0;
    for (int c = CDB_N-1; c >= 0; c--)
      if (v[c] && idx[c*ROB_BITS +: ROB_BITS] == tag) res = {1'b1, val[c*32 +: 32]};
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i]     = cdb_hit(r_dep1[i], cdb_valid, cdb_idx, cdb_value);
      w_wk2[i]     = cdb_hit(r_dep2[i], cdb_valid, cdb_idx, cdb_value);
      w_cmt_hit[i] = commit_valid && r_vld[i] && r_type[i][3] && (r_tag[i] == commit_rob_idx);
    end
    w_pk1 = cdb_hit(inst_dep1, cdb_valid, cdb_idx, cdb_value);
    w_pk2 = cdb_hit(inst_dep2, cdb_valid, cdb_idx, cdb_value);
  end

  assign w_cmt_eff = r_cmt | w_cmt_hit;

  // Committed stores are the oldest contiguous run starting at head; they are the flush survivors
  always_comb begin
    w_ncmt = '0;
    w_keep = '0;
    w_run  = 1'b1;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (w_run && r_vld[w_idx] && r_type[w_idx][3] && w_cmt_eff[w_idx]) begin
        w_ncmt        = w_ncmt + (PW+1)'(1);
        w_keep[w_idx] = 1'b1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  assign w_head_elig = r_vld[r_head] && !r_hd1[r_head] && !r_hd2[r_head] &&
                       (!r_type[r_head][3] || w_cmt_eff[r_head]);
  assign w_addr = r_r1[r_head] + {{20{r_off[r_head][11]}}, r_off[r_head]};
  assign w_done = rdy_in && (r_state == S_BUSY) && mem_ready;
  // A load completing in a flush cycle is already squashed, so it must not pop as well
  assign w_pop  = w_done && (r_mem_wr || !flush_in);
  assign w_push = rdy_in && inst_valid && !full && !flush_in;

  always_comb begin
    w_ext = mem_rdata;
    case (r_mem_len)
      3'd0:    w_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    w_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    w_ext = {24'd0, mem_rdata[7:0]};
      3'd5:    w_ext = {16'd0, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  assign full      = (r_count == (PW+1)'(DEPTH));
  assign count     = r_count;
  assign wb_valid  = w_done && !r_mem_wr && !flush_in;
  assign wb_idx    = r_tag[r_head];
  assign wb_value  = w_ext;
  assign st_done   = w_done && r_mem_wr;
  assign mem_valid = r_mem_valid;
  assign mem_wr    = r_mem_wr;
  assign mem_len   = r_mem_len;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head <= '0; r_tail <= '0; r_count <= '0; r_state <= S_IDLE;
      r_mem_valid <= 1'b0; r_mem_wr <= 1'b0; r_mem_len <= '0; r_mem_addr <= '0; r_mem_wdata <= '0;
      r_vld <= '0; r_cmt <= '0; r_hd1 <= '0; r_hd2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i] <= '0; r_tag[i] <= '0; r_dep1[i] <= '0; r_dep2[i] <= '0;
        r_r1[i] <= '0; r_r2[i] <= '0; r_off[i] <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && r_hd1[i] && w_wk1[i][32]) begin r_r1[i] <= w_wk1[i][31:0]; r_hd1[i] <= 1'b0; end
        if (r_vld[i] && r_hd2[i] && w_wk2[i][32]) begin r_r2[i] <= w_wk2[i][31:0]; r_hd2[i] <= 1'b0; end
        if (w_cmt_hit[i]) r_cmt[i] <= 1'b1;
        if (flush_in && !w_keep[i]) r_vld[i] <= 1'b0;
      end
      if (w_pop) r_vld[r_head] <= 1'b0;
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_cmt[r_tail]  <= 1'b0;
        r_type[r_tail] <= inst_type;
        r_tag[r_tail]  <= inst_rob_idx;
        r_dep1[r_tail] <= inst_dep1;
        r_dep2[r_tail] <= inst_dep2;
        r_off[r_tail]  <= inst_offset;
        r_r1[r_tail]   <= (inst_has_dep1 && w_pk1[32]) ? w_pk1[31:0] : inst_r1;
        r_r2[r_tail]   <= (inst_has_dep2 && w_pk2[32]) ? w_pk2[31:0] : inst_r2;
        r_hd1[r_tail]  <= inst_has_dep1 && !w_pk1[32];
        r_hd2[r_tail]  <= inst_has_dep2 && !w_pk2[32];
      end
      r_head <= r_head + PW'(w_pop);
      if (flush_in) begin
        r_tail  <= r_head + w_ncmt[PW-1:0];
        r_count <= w_ncmt - (PW+1)'(w_pop);
      end else begin
        r_tail  <= r_tail + PW'(w_push);
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
      case (r_state)
        S_IDLE: if (w_head_elig && !flush_in) begin
          r_mem_valid <= 1'b1;
          r_mem_wr    <= r_type[r_head][3];
          r_mem_len   <= r_type[r_head][2:0];
          r_mem_addr  <= w_addr;
          r_mem_wdata <= r_r2[r_head];
          r_state     <= S_BUSY;
        end
        S_BUSY: if (mem_ready) begin
          r_mem_valid <= 1'b0;
          r_state     <= S_IDLE;
        end else if (flush_in && !r_mem_wr) begin
          r_state <= S_DRAIN;
        end
        S_DRAIN: if (mem_ready) begin
          r_mem_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
